// File: rtl/alu_spi_responder_if.sv
// SPI pins plus ALU operand/result bus and frame status for alu_spi_responder.
`timescale 1ns/1ps

interface alu_spi_responder_if #(
  parameter int unsigned WIDTH = 4
);

  // SPI pins
  logic                 sclk;
  logic                 cs_n;
  logic                 mosi;
  logic                 miso;

  // ALU operand and result bus
  logic [WIDTH-1:0]     alu_a;
  logic [WIDTH-1:0]     alu_b;
  logic [1:0]           alu_opcode;
  logic [2*WIDTH-1:0]   alu_result;
  logic                 alu_n;
  logic                 alu_z;
  logic                 alu_c;
  logic                 alu_v;

  // Frame status
  logic                 busy;
  logic                 frame_valid;
  logic                 frame_err;

  // Responder side: SPI slave, drives the ALU operands
  modport slave (
    input  sclk, cs_n, mosi,
    input  alu_result, alu_n, alu_z, alu_c, alu_v,
    output miso,
    output alu_a, alu_b, alu_opcode,
    output busy, frame_valid, frame_err
  );

  // Environment side: SPI master plus the ALU itself
  modport master (
    output sclk, cs_n, mosi,
    output alu_result, alu_n, alu_z, alu_c, alu_v,
    input  miso,
    input  alu_a, alu_b, alu_opcode,
    input  busy, frame_valid, frame_err
  );

endinterface

// File: rtl/alu_spi_responder.sv
// SPI mode-0 slave front end for the ALU: deserializes {opcode, A, B},
// drives the ALU operands, then shifts {result, N, Z, C, V} back on MISO
// within the same chip-select window. SPI pins are oversampled on clk.
`timescale 1ns/1ps

module alu_spi_responder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_spi_responder_if.slave    bus
);

  localparam int unsigned CMD_BITS = 2 + 2 * WIDTH;
  localparam int unsigned RSP_BITS = 2 * WIDTH + 4;
  localparam int unsigned CNT_W    = $clog2(RSP_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_LOAD,
    S_RESP,
    S_DONE
  } state_t;

  // Synchronizer chains; bit 0 is the newest sample
  logic [2:0]          sclk_sync;
  logic [2:0]          cs_sync;
  logic [1:0]          mosi_sync;

  // Edge strobes and sampled data
  logic                sclk_rise_c;
  logic                sclk_fall_c;
  logic                cs_fall_c;
  logic                cs_rise_c;
  logic                mosi_bit_c;
  logic [CMD_BITS-1:0] cmd_word_c;
  logic [RSP_BITS-1:0] rsp_word_c;

  // State and datapath registers
  state_t              state_q, state_nxt;
  logic [CMD_BITS-2:0] rx_q, rx_nxt;
  logic [RSP_BITS-2:0] tx_q, tx_nxt;
  logic [CNT_W-1:0]    cnt_q, cnt_nxt;
  logic                over_q, over_nxt;
  logic                miso_q, miso_nxt;
  logic [WIDTH-1:0]    alu_a_q, alu_a_nxt;
  logic [WIDTH-1:0]    alu_b_q, alu_b_nxt;
  logic [1:0]          alu_op_q, alu_op_nxt;
  logic                busy_q, busy_nxt;
  logic                valid_q, valid_nxt;
  logic                err_q, err_nxt;

  // Two-flop synchronizers plus a third sclk/cs_n stage for edge detection.
  // cs_n stages clear to 0 so a chip select held low through reset never
  // looks like a fresh falling edge; the frame in flight is simply ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '0;
      mosi_sync <= '0;
    end else begin
      sclk_sync <= {sclk_sync[1:0], bus.sclk};
      cs_sync   <= {cs_sync[1:0], bus.cs_n};
      mosi_sync <= {mosi_sync[0], bus.mosi};
    end
  end

  // Single-cycle edge strobes and the word views used by the FSM
  always_comb begin
    sclk_rise_c = sclk_sync[1] & ~sclk_sync[2];
    sclk_fall_c = ~sclk_sync[1] & sclk_sync[2];
    cs_fall_c   = ~cs_sync[1] & cs_sync[2];
    cs_rise_c   = cs_sync[1] & ~cs_sync[2];
    mosi_bit_c  = mosi_sync[1];
    cmd_word_c  = {rx_q, mosi_bit_c};
    rsp_word_c  = {bus.alu_result, bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v};
  end

  // State and datapath register bank
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rx_q     <= '0;
      tx_q     <= '0;
      cnt_q    <= '0;
      over_q   <= 1'b0;
      miso_q   <= 1'b0;
      alu_a_q  <= '0;
      alu_b_q  <= '0;
      alu_op_q <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      rx_q     <= rx_nxt;
      tx_q     <= tx_nxt;
      cnt_q    <= cnt_nxt;
      over_q   <= over_nxt;
      miso_q   <= miso_nxt;
      alu_a_q  <= alu_a_nxt;
      alu_b_q  <= alu_b_nxt;
      alu_op_q <= alu_op_nxt;
      busy_q   <= busy_nxt;
      valid_q  <= valid_nxt;
      err_q    <= err_nxt;
    end
  end

  // Frame FSM: next state, shift registers, operand load and status pulses
  always_comb begin
    state_nxt  = state_q;
    rx_nxt     = rx_q;
    tx_nxt     = tx_q;
    cnt_nxt    = cnt_q;
    over_nxt   = over_q;
    miso_nxt   = miso_q;
    alu_a_nxt  = alu_a_q;
    alu_b_nxt  = alu_b_q;
    alu_op_nxt = alu_op_q;
    valid_nxt  = 1'b0;
    err_nxt    = 1'b0;

    if (cs_rise_c && (state_q != S_IDLE)) begin
      // Chip select released: close the frame and report how it ended
      state_nxt = S_IDLE;
      miso_nxt  = 1'b0;
      cnt_nxt   = '0;
      over_nxt  = 1'b0;
      if ((state_q == S_DONE) && !over_q) begin
        valid_nxt = 1'b1;
      end else begin
        err_nxt = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // sclk edges coinciding with the cs_n fall are deliberately dropped
          miso_nxt = 1'b0;
          cnt_nxt  = '0;
          over_nxt = 1'b0;
          if (cs_fall_c) begin
            state_nxt = S_CMD;
          end
        end

        S_CMD: begin
          miso_nxt = 1'b0;
          if (sclk_rise_c) begin
            rx_nxt  = cmd_word_c[CMD_BITS-2:0];
            cnt_nxt = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(CMD_BITS - 1)) begin
              alu_op_nxt = cmd_word_c[CMD_BITS-1 -: 2];
              alu_a_nxt  = cmd_word_c[2*WIDTH-1 -: WIDTH];
              alu_b_nxt  = cmd_word_c[WIDTH-1:0];
              state_nxt  = S_WAIT_LOAD;
            end
          end
        end

        S_WAIT_LOAD: begin
          // ALU has had at least half an sclk period to settle by this fall
          miso_nxt = 1'b0;
          if (sclk_fall_c) begin
            miso_nxt  = rsp_word_c[RSP_BITS-1];
            tx_nxt    = rsp_word_c[RSP_BITS-2:0];
            cnt_nxt   = '0;
            state_nxt = S_RESP;
          end
        end

        S_RESP: begin
          // cnt_q is the index of the bit currently on miso
          if (sclk_fall_c) begin
            if (cnt_q == CNT_W'(RSP_BITS - 1)) begin
              miso_nxt  = 1'b0;
              tx_nxt    = '0;
              state_nxt = S_DONE;
            end else begin
              miso_nxt = tx_q[RSP_BITS-2];
              tx_nxt   = {tx_q[RSP_BITS-3:0], 1'b0};
              cnt_nxt  = cnt_q + CNT_W'(1);
            end
          end
        end

        S_DONE: begin
          miso_nxt = 1'b0;
          if (sclk_rise_c) begin
            over_nxt = 1'b1;
          end
        end

        default: begin
          state_nxt = S_IDLE;
          miso_nxt  = 1'b0;
          cnt_nxt   = '0;
          over_nxt  = 1'b0;
        end
      endcase
    end

    busy_nxt = (state_nxt != S_IDLE);
  end

  // Registered outputs onto the bus
  assign bus.miso        = miso_q;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_opcode  = alu_op_q;
  assign bus.busy        = busy_q;
  assign bus.frame_valid = valid_q;
  assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_alu_spi_responder.sv
// Directed bench for alu_spi_responder: an SPI-master task drives frames,
// a small ALU stub answers on the bus, and one compare process checks the
// DUT against a frame-level model at the end of every sclk half-period.
`timescale 1ns/1ps

module tb_alu_spi_responder;

  localparam int unsigned W        = 4;
  localparam int unsigned CMD_BITS = 2 + 2 * W;
  localparam int unsigned RSP_BITS = 2 * W + 4;
  localparam int          FULL_CYC = CMD_BITS + RSP_BITS;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  alu_spi_responder_if #(.WIDTH(W)) bus ();

  alu_spi_responder #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ALU stub: op0 add, op1 subtract, op2 and, op3 multiply; returns {result, N, Z, C, V}
  function automatic logic [RSP_BITS-1:0] alu_stub(input logic [1:0] op,
                                                   input logic [W-1:0] a,
                                                   input logic [W-1:0] b);
    logic [2*W-1:0] r;
    logic [W:0]     t;
    logic           c;
    r = '0;
    t = '0;
    c = 1'b0;
    case (op)
      2'd0: begin
        t = {1'b0, a} + {1'b0, b};
        r = (2*W)'(t);
        c = t[W];
      end
      2'd1: begin
        t = {1'b0, a} - {1'b0, b};
        r = (2*W)'(t[W-1:0]);
        c = t[W];
      end
      2'd2: r = (2*W)'(a & b);
      default: r = (2*W)'(a) * (2*W)'(b);
    endcase
    return {r, r[2*W-1], (r == '0), c, 1'b0};
  endfunction

  assign {bus.alu_result, bus.alu_n, bus.alu_z, bus.alu_c, bus.alu_v} =
    alu_stub(bus.alu_opcode, bus.alu_a, bus.alu_b);

  // Scoreboard counters
  int nvec = 0;
  int nerr = 0;

  // Frame-level model of the observable outputs
  logic [1:0]   m_op;
  logic [W-1:0] m_a;
  logic [W-1:0] m_b;
  logic         m_busy;
  logic         exp_miso;
  int           exp_nv;
  int           exp_ne;
  int           nv;
  int           ne;
  bit           chk_now;
  bit           chk_end;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: counts status pulses every cycle, checks outputs when asked
  always @(negedge clk) begin
    if (bus.frame_valid === 1'b1) nv++;
    if (bus.frame_err === 1'b1) ne++;
    if (chk_now) begin
      check("miso",       32'(bus.miso),       32'(exp_miso));
      check("alu_opcode", 32'(bus.alu_opcode), 32'(m_op));
      check("alu_a",      32'(bus.alu_a),      32'(m_a));
      check("alu_b",      32'(bus.alu_b),      32'(m_b));
      check("busy",       32'(bus.busy),       32'(m_busy));
    end
    if (chk_end) begin
      check("frame_valid_pulses", 32'(nv), 32'(exp_nv));
      check("frame_err_pulses",   32'(ne), 32'(exp_ne));
      nv = 0;
      ne = 0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One sclk half-period (5 clk); outputs are checked just before it ends
  task automatic half();
    tick(4);
    chk_now = 1'b1;
    tick(1);
    chk_now = 1'b0;
  endtask

  // Master frame: ncyc full sclk cycles, optional 1-cycle reset before cycle
  // rst_at, then cs_n high for gap clk before the pulse counts are checked.
  task automatic run_frame(input logic [CMD_BITS-1:0] cmd, input int ncyc,
                           input int rst_at, input int gap,
                           output logic [RSP_BITS-1:0] cap);
    logic [RSP_BITS-1:0] rsp;
    bit                  dead;
    dead     = 1'b0;
    rsp      = '0;
    cap      = '0;
    bus.cs_n = 1'b0;
    bus.mosi = cmd[CMD_BITS-1];
    m_busy   = 1'b1;
    exp_miso = 1'b0;
    half();
    for (int i = 0; i < ncyc; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        tick(1);
        rst    = 1'b0;
        dead   = 1'b1;
        m_op   = '0;
        m_a    = '0;
        m_b    = '0;
        m_busy = 1'b0;
      end
      if (i > 0) bus.mosi = (i < CMD_BITS) ? cmd[CMD_BITS-1-i] : 1'b0;
      exp_miso = (!dead && i >= CMD_BITS && i < FULL_CYC) ? rsp[FULL_CYC-1-i] : 1'b0;
      half();
      if (i >= CMD_BITS && i < FULL_CYC) cap = {cap[RSP_BITS-2:0], bus.miso};
      bus.sclk = 1'b1;
      if (i == CMD_BITS - 1 && !dead) begin
        m_op = cmd[CMD_BITS-1 -: 2];
        m_a  = cmd[2*W-1 -: W];
        m_b  = cmd[W-1:0];
        rsp  = alu_stub(m_op, m_a, m_b);
      end
      half();
      bus.sclk = 1'b0;
    end
    exp_miso = 1'b0;
    half();
    bus.cs_n = 1'b1;
    m_busy   = 1'b0;
    exp_nv   = (!dead && ncyc == FULL_CYC) ? 1 : 0;
    exp_ne   = (!dead && ncyc != FULL_CYC) ? 1 : 0;
    tick(gap - 1);
    chk_now = 1'b1;
    chk_end = 1'b1;
    tick(1);
    chk_now = 1'b0;
    chk_end = 1'b0;
  endtask

  task automatic check_ops(input string tag, input logic [1:0] op,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    check({tag, "_opcode"}, 32'(bus.alu_opcode), 32'(op));
    check({tag, "_a"},      32'(bus.alu_a),      32'(a));
    check({tag, "_b"},      32'(bus.alu_b),      32'(b));
  endtask

  initial begin
    logic [RSP_BITS-1:0] cap;
    rst      = 1'b1;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    m_op     = '0;
    m_a      = '0;
    m_b      = '0;
    m_busy   = 1'b0;
    exp_miso = 1'b0;
    exp_nv   = 0;
    exp_ne   = 0;
    nv       = 0;
    ne       = 0;
    chk_now  = 1'b0;
    chk_end  = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(5);

    // Reset state
    check("rst_miso",        32'(bus.miso),        32'd0);
    check("rst_busy",        32'(bus.busy),        32'd0);
    check("rst_frame_valid", 32'(bus.frame_valid), 32'd0);
    check("rst_frame_err",   32'(bus.frame_err),   32'd0);
    check_ops("rst", 2'b00, 4'h0, 4'h0);

    // 5 - 5: zero result, Z set
    run_frame(10'b01_0101_0101, FULL_CYC, -1, 8, cap);
    check("f1_resp", 32'(cap), 32'h004);
    check_ops("f1", 2'b01, 4'h5, 4'h5);

    // Abort after 6 command bits: operands untouched
    run_frame(10'b10_0011_0110, 6, -1, 8, cap);
    check_ops("abort", 2'b01, 4'h5, 4'h5);
    check("abort_miso", 32'(bus.miso), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);

    // F + 1: carry out into result bit 4 and C flag
    run_frame(10'b00_1111_0001, FULL_CYC, -1, 8, cap);
    check("f2_resp", 32'(cap), 32'h102);
    check_ops("f2", 2'b00, 4'hF, 4'h1);

    // Full frame plus one extra sclk cycle: error, operands still loaded
    run_frame(10'b10_1100_1010, FULL_CYC + 1, -1, 8, cap);
    check("over_resp", 32'(cap), 32'h080);
    check_ops("over", 2'b10, 4'hC, 4'hA);

    // Reset at bit 4: everything back to reset values, no pulse
    run_frame(10'b00_0111_0110, FULL_CYC, 4, 8, cap);
    check_ops("rstmid", 2'b00, 4'h0, 4'h0);
    check("rstmid_miso", 32'(bus.miso), 32'd0);

    // A * 3 after the reset frame
    run_frame(10'b11_1010_0011, FULL_CYC, -1, 8, cap);
    check("f6_resp", 32'(cap), 32'h1E0);
    check_ops("f6", 2'b11, 4'hA, 4'h3);

    // Back-to-back frames with a 4-clk cs_n gap
    run_frame(10'b00_0111_0110, FULL_CYC, -1, 4, cap);
    check("b2b1_resp", 32'(cap), 32'h0D0);
    run_frame(10'b10_1111_0110, FULL_CYC, -1, 8, cap);
    check("b2b2_resp", 32'(cap), 32'h060);
    check_ops("b2b2", 2'b10, 4'hF, 4'h6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/alu_spi_responder.md
# alu_spi_responder

SPI-mode-0 slave front end for the FPGA-side ALU. An external master sends a command frame (opcode, A, B) over SPI; this block deserializes it, drives the ALU operand inputs, captures the ALU result and flags, and serializes them back on MISO within the same chip-select window. All SPI pins are oversampled in the `clk` domain; no logic runs on `sclk`.

## Interface

- `WIDTH`, 4, ALU operand width; command frame is 2+2·WIDTH bits, response frame is 2·WIDTH+4 bits
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `sclk`  in  1  SPI clock from master, asynchronous
- `cs_n`  in  1  SPI chip select, active low, asynchronous
- `mosi`  in  1  SPI data from master, asynchronous
- `miso`  out  1  SPI data to master
- `alu_a`  out  WIDTH  registered operand A to ALU
- `alu_b`  out  WIDTH  registered operand B to ALU
- `alu_opcode`  out  2  registered opcode to ALU
- `alu_result`  in  2·WIDTH  ALU result (combinational from alu_a/alu_b/alu_opcode)
- `alu_n`, `alu_z`, `alu_c`, `alu_v`  in  1 each  ALU flags
- `busy`  out  1  high while a frame is in progress (cs_n low, synchronized)
- `frame_valid`  out  1  one-cycle pulse: complete frame ended cleanly
- `frame_err`  out  1  one-cycle pulse: frame ended with wrong bit count

## Operation

- Synchronizers: 2-flop on `sclk`, `cs_n`, `mosi`; third `sclk`/`cs_n` stage for edge detect. Rise/fall events are single-cycle strobes.
- Command frame, MSB first: {opcode[1:0], A[WIDTH-1:0], B[WIDTH-1:0]}, sampled on sclk rising edges.
- Response frame, MSB first: {result[2·WIDTH-1:0], N, Z, C, V}; MISO changes on sclk falling edges.
- FSM states:
  - IDLE: miso=0, bit counter=0. cs_n fall → CMD.
  - CMD: each sclk rise shifts mosi into rx register, counter+1. On the rise that completes 2+2·WIDTH bits, load alu_opcode/alu_a/alu_b from rx register in the same cycle → WAIT_LOAD.
  - WAIT_LOAD: miso=0. Next sclk fall: load tx register with {alu_result, flags}, miso=tx MSB, counter reset → RESP.
  - RESP: each sclk fall shifts tx left (zero fill), counter+1. Falling edge after last response bit → DONE. Rising edges ignored.
  - DONE: miso=0; any further sclk rising edge marks frame as over-length.
- cs_n rise in any non-IDLE state → IDLE. frame_valid pulses if state was DONE with no over-length edge; otherwise frame_err pulses. Exactly one of the two per frame.
- Operands update only at command completion; aborted frames leave alu_a/alu_b/alu_opcode unchanged.
- cs_n fall and sclk edge in same cycle: cs_n processed first, the edge is ignored.
- Reset values: miso=0, alu_a=0, alu_b=0, alu_opcode=0, busy=0, frame_valid=0, frame_err=0, FSM=IDLE. Reset mid-frame: immediate IDLE, no pulse; remainder of that frame ignored until cs_n goes high then low again.

## Timing

- Input-to-event latency: 3 clk cycles from pin transition to edge strobe.
- Constraint: sclk high and low phases each ≥ 4 clk periods; cs_n setup to first sclk rise ≥ 4 clk periods.
- ALU operands valid 1 cycle after last command rising-edge strobe; alu_result sampled ≥ 1 sclk half-period later (≥ 4 clk), so ALU combinational path is settled.
- miso valid 1 clk after the sclk-fall strobe, i.e. ≤ 4 clk after the pin edge — before the next sclk rise under the constraint.
- frame_valid/frame_err: asserted 1 clk after the cs_n-rise strobe, high exactly 1 cycle.
- Back-to-back frames: cs_n high ≥ 4 clk between frames supported with no lost bits.

## Test plan

- WIDTH=4, clk 10 ns, sclk 100 ns. Frame cmd 01_0101_0101, ALU stub returns result 8'h00, NZCV=0100 → alu_opcode=01, alu_a=5, alu_b=5; MISO bits 0000_0000_0100; frame_valid one pulse.
- Cmd 00_1111_0001, stub returns 8'h10, NZCV=0010 → MISO 0001_0000_0010; miso=0 during all 10 command bits.
- cs_n raised after 6 command bits → frame_err pulse, operands keep previous values (5,5,01), miso=0, busy=0.
- Full frame plus one extra sclk cycle → frame_err, not frame_valid; operands still updated.
- rst asserted for 1 cycle at bit 4 of a frame → all outputs at reset values, no pulse at following cs_n rise; next full frame cmd 11_1010_0011 → alu_opcode=11, a=A, b=3, frame_valid.
- Two back-to-back frames with 40 ns cs_n gap → two frame_valid pulses, second response reflects second operands.
